ofs_asp_irq_csr: RTL and testbench

//  Interrupt-source end of the ASP interrupt path. Latches rising edges from DMA_0 (bit0), kernel (bit1) and DMA_1 (bit2).

---
 rtl/ofs_asp_irq_pkg.sv | 20 ++
 rtl/ofs_asp_irq_csr_if.sv | 31 +++
 rtl/ofs_asp_irq_arbiter.sv | 19 +
 rtl/ofs_asp_irq_csr.sv | 146 ++++++++++++++
 tb/tb_ofs_asp_irq_csr.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/ofs_asp_irq_pkg.sv
// rtl/ofs_asp_irq_pkg.sv - CSR word offsets, ID constant and request FSM states for the ASP IRQ CSR block
package ofs_asp_irq_pkg;

  // CSR word addresses (byte offset / 8)
  localparam int CSR_ID         = 0;
  localparam int CSR_STATUS     = 1;
  localparam int CSR_MASK       = 2;
  localparam int CSR_CLEAR      = 3;
  localparam int CSR_CTRL       = 4;
  localparam int CSR_STATS_BASE = 8;

  localparam logic [63:0] ID_VALUE = 64'h0A5B_1000_0000_0001;
  localparam int          STATS_W  = 32;

  typedef enum logic {
    IDLE,
    REQ
  } t_irq_req_state;

endpackage

// File: rtl/ofs_asp_irq_csr_if.sv
// rtl/ofs_asp_irq_csr_if.sv - host CSR responder bus plus interrupt request channel
interface ofs_asp_irq_csr_if #(
  parameter int NUM_IRQ = 4,
  parameter int DATA_W  = 64,
  parameter int ADDR_W  = 4
) ();

  logic [ADDR_W-1:0]          avs_address;
  logic                       avs_read;
  logic                       avs_write;
  logic [DATA_W-1:0]          avs_writedata;
  logic [DATA_W/8-1:0]        avs_byteenable;
  logic [DATA_W-1:0]          avs_readdata;
  logic                       avs_readdatavalid;
  logic                       avs_waitrequest;
  logic                       irq_req_valid;
  logic [$clog2(NUM_IRQ)-1:0] irq_req_id;
  logic                       irq_req_ready;

  // master is the host/PIM side; slave is the IRQ CSR block
  modport master (
    output avs_address, avs_read, avs_write, avs_writedata, avs_byteenable, irq_req_ready,
    input  avs_readdata, avs_readdatavalid, avs_waitrequest, irq_req_valid, irq_req_id
  );

  modport slave (
    input  avs_address, avs_read, avs_write, avs_writedata, avs_byteenable, irq_req_ready,
    output avs_readdata, avs_readdatavalid, avs_waitrequest, irq_req_valid, irq_req_id
  );

endinterface

// File: rtl/ofs_asp_irq_arbiter.sv
// rtl/ofs_asp_irq_arbiter.sv - fixed-priority pick, lowest index wins
module ofs_asp_irq_arbiter #(
  parameter int N    = 4,
  parameter int ID_W = $clog2(N)
) (
  input  logic [N-1:0]    req,
  output logic            any,
  output logic [ID_W-1:0] id
);

  always_comb begin
    any = |req;
    id  = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) id = ID_W'(i);
    end
  end

endmodule

// File: rtl/ofs_asp_irq_csr.sv
// rtl/ofs_asp_irq_csr.sv - ASP interrupt source: edge latch, status/mask/clear CSRs, request FSM
// Optional per-line accepted-request counters when ASP_IRQ_STATS_EN is defined.
module ofs_asp_irq_csr
  import ofs_asp_irq_pkg::*;
#(
  parameter int NUM_IRQ = 4,
  parameter int DATA_W  = 64,
  parameter int ADDR_W  = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_IRQ-1:0] irq_src,
  ofs_asp_irq_csr_if.slave   bus
);

  localparam int ID_W = $clog2(NUM_IRQ);

  logic [NUM_IRQ-1:0] src_q, pending, sent, mask;
  logic [NUM_IRQ-1:0] set_v, clr_v, accept_v, eligible;
  logic               gie, waitreq, rd_en, wr_en, handshake;
  logic [DATA_W-1:0]  rd_value, rdata;
  logic               rvalid;
  logic               arb_any;
  logic [ID_W-1:0]    arb_id, req_id, req_id_n;
  t_irq_req_state     state, state_n;
  logic               unused_bits;

  assign unused_bits = ^{bus.avs_writedata, bus.avs_byteenable};

  // A simultaneous read wins; the write is dropped
  assign rd_en = bus.avs_read & ~waitreq;
  assign wr_en = bus.avs_write & ~bus.avs_read & ~waitreq;

  assign set_v     = irq_src & ~src_q;
  assign clr_v     = (wr_en && bus.avs_address == ADDR_W'(CSR_CLEAR)) ?
                     bus.avs_writedata[NUM_IRQ-1:0] : '0;
  assign handshake = (state == REQ) & bus.irq_req_ready;
  assign accept_v  = handshake ? (NUM_IRQ'(1) << req_id) : '0;
  assign eligible  = pending & ~sent & ~mask & {NUM_IRQ{gie}};

  always_ff @(posedge clk) begin
    if (reset) begin
      src_q   <= '0;
      pending <= '0;
      sent    <= '0;
      mask    <= '1;
      gie     <= 1'b0;
      waitreq <= 1'b1;
    end else begin
      src_q   <= irq_src;
      waitreq <= 1'b0;
      // A new edge beats a clear; clearing also re-arms signalling
      pending <= set_v | (pending & ~clr_v);
      sent    <= (sent | accept_v) & ~clr_v;
      if (wr_en && bus.avs_address == ADDR_W'(CSR_MASK)) begin
        for (int i = 0; i < NUM_IRQ; i++) begin
          if (bus.avs_byteenable[i/8]) mask[i] <= bus.avs_writedata[i];
        end
      end
      if (wr_en && bus.avs_address == ADDR_W'(CSR_CTRL)) gie <= bus.avs_writedata[0];
    end
  end

  ofs_asp_irq_arbiter #(.N(NUM_IRQ), .ID_W(ID_W)) u_arb (
    .req (eligible),
    .any (arb_any),
    .id  (arb_id)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      req_id <= '0;
    end else begin
      state  <= state_n;
      req_id <= req_id_n;
    end
  end

  // Once in REQ the request is never retracted, even if masked or cleared
  always_comb begin
    state_n  = state;
    req_id_n = req_id;
    case (state)
      IDLE: if (arb_any) begin
        state_n  = REQ;
        req_id_n = arb_id;
      end
      REQ: if (bus.irq_req_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  assign bus.irq_req_valid = (state == REQ);
  assign bus.irq_req_id    = req_id;

`ifdef ASP_IRQ_STATS_EN
  logic [STATS_W-1:0] stat_cnt [NUM_IRQ];

  for (genvar g = 0; g < NUM_IRQ; g++) begin : gen_stats
    logic [STATS_W-1:0] cnt;
    always_ff @(posedge clk) begin
      if (reset) begin
        cnt <= '0;
      end else if (wr_en && bus.avs_address == ADDR_W'(CSR_STATS_BASE + g)) begin
        cnt <= '0;
      end else if (accept_v[g] && cnt != '1) begin
        cnt <= cnt + 1'b1;
      end
    end
    assign stat_cnt[g] = cnt;
  end
`endif

  always_comb begin
    rd_value = '0;
    case (bus.avs_address)
      ADDR_W'(CSR_ID):     rd_value = DATA_W'(ID_VALUE);
      ADDR_W'(CSR_STATUS): rd_value = DATA_W'(pending);
      ADDR_W'(CSR_MASK):   rd_value = DATA_W'(mask);
      ADDR_W'(CSR_CTRL):   rd_value = DATA_W'(gie);
      default: begin
`ifdef ASP_IRQ_STATS_EN
        for (int i = 0; i < NUM_IRQ; i++) begin
          if (bus.avs_address == ADDR_W'(CSR_STATS_BASE + i)) rd_value = DATA_W'(stat_cnt[i]);
        end
`endif
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rdata  <= '0;
      rvalid <= 1'b0;
    end else begin
      rvalid <= rd_en;
      if (rd_en) rdata <= rd_value;
    end
  end

  assign bus.avs_readdata      = rdata;
  assign bus.avs_readdatavalid = rvalid;
  assign bus.avs_waitrequest   = waitreq;

endmodule

// File: tb/tb_ofs_asp_irq_csr.sv
// tb/tb_ofs_asp_irq_csr.sv - directed self-checking bench for ofs_asp_irq_csr
module tb_ofs_asp_irq_csr;

  localparam logic [63:0] EXP_ID = 64'h0A5B_1000_0000_0001;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] irq_src;
  int         tests_run = 0;
  int         tests_failed = 0;
  logic [1:0] acc_q[$];
  logic [63:0] rd;
  logic        stable;

  ofs_asp_irq_csr_if #(.NUM_IRQ(4), .DATA_W(64), .ADDR_W(4)) bus ();

  ofs_asp_irq_csr #(.NUM_IRQ(4), .DATA_W(64), .ADDR_W(4)) dut (
    .clk     (clk),
    .reset   (reset),
    .irq_src (irq_src),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!reset && bus.irq_req_valid && bus.irq_req_ready) acc_q.push_back(bus.irq_req_id);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] acc_at(input int i);
    return (acc_q.size() > i) ? 64'(acc_q[i]) : 64'hDEAD;
  endfunction

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_bus;
    int n = 0;
    while (bus.avs_waitrequest && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) check("waitrequest_timeout", 64'(bus.avs_waitrequest), 64'd0);
  endtask

  task automatic csr_write(input logic [3:0] a, input logic [63:0] d, input logic [7:0] be = 8'hFF);
    wait_bus();
    bus.avs_address    = a;
    bus.avs_writedata  = d;
    bus.avs_byteenable = be;
    bus.avs_write      = 1'b1;
    @(negedge clk);
    bus.avs_write      = 1'b0;
  endtask

  task automatic csr_read(input logic [3:0] a, output logic [63:0] d);
    wait_bus();
    bus.avs_address = a;
    bus.avs_read    = 1'b1;
    @(negedge clk);
    bus.avs_read    = 1'b0;
    check("readdatavalid", 64'(bus.avs_readdatavalid), 64'd1);
    d = bus.avs_readdata;
  endtask

  task automatic pulse(input logic [3:0] bits);
    irq_src = bits;
    @(negedge clk);
    irq_src = 4'h0;
  endtask

  task automatic wait_valid(input int budget);
    int n = 0;
    while (!bus.irq_req_valid && n < budget) begin
      @(negedge clk);
      n++;
    end
  endtask

  initial begin
    reset = 1'b1;
    irq_src = 4'h0;
    bus.avs_address = '0;
    bus.avs_read = 1'b0;
    bus.avs_write = 1'b0;
    bus.avs_writedata = '0;
    bus.avs_byteenable = '0;
    bus.irq_req_ready = 1'b0;

    // reset state
    wait_cycles(3);
    check("rst_waitrequest", 64'(bus.avs_waitrequest), 64'd1);
    check("rst_readdata", bus.avs_readdata, 64'd0);
    check("rst_readdatavalid", 64'(bus.avs_readdatavalid), 64'd0);
    check("rst_valid", 64'(bus.irq_req_valid), 64'd0);
    check("rst_id", 64'(bus.irq_req_id), 64'd0);
    reset = 1'b0;
    check("waitreq_before_edge", 64'(bus.avs_waitrequest), 64'd1);
    @(negedge clk);
    check("waitreq_after_edge", 64'(bus.avs_waitrequest), 64'd0);
    csr_read(4'd0, rd);  check("id_value", rd, EXP_ID);
    csr_read(4'd2, rd);  check("mask_reset", rd, 64'hF);
    csr_read(4'd1, rd);  check("status_reset", rd, 64'h0);
    csr_read(4'd4, rd);  check("ctrl_reset", rd, 64'h0);
    csr_read(4'd7, rd);  check("unmapped_read", rd, 64'h0);

    // read+write together: read serviced, write dropped; byteenable honoured
    wait_bus();
    bus.avs_address = 4'd2;
    bus.avs_writedata = 64'h0;
    bus.avs_byteenable = 8'hFF;
    bus.avs_read = 1'b1;
    bus.avs_write = 1'b1;
    @(negedge clk);
    bus.avs_read = 1'b0;
    bus.avs_write = 1'b0;
    check("rw_readdata", bus.avs_readdata, 64'hF);
    csr_read(4'd2, rd);  check("rw_write_dropped", rd, 64'hF);
    csr_write(4'd2, 64'h0, 8'h00);
    csr_read(4'd2, rd);  check("mask_be_zero", rd, 64'hF);
    check("no_req_masked", 64'(bus.irq_req_valid), 64'd0);

    // single request held under back-pressure
    csr_write(4'd2, 64'h0);
    csr_write(4'd4, 64'h1);
    pulse(4'h2);
    wait_valid(3);
    check("t2_valid", 64'(bus.irq_req_valid), 64'd1);
    check("t2_id", 64'(bus.irq_req_id), 64'd1);
    stable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      stable &= bus.irq_req_valid && (bus.irq_req_id == 2'd1);
    end
    check("t2_hold_stable", 64'(stable), 64'd1);
    csr_read(4'd1, rd);  check("t2_status", rd, 64'h2);
    bus.irq_req_ready = 1'b1;
    @(negedge clk);
    check("t2_accept_count", 64'(acc_q.size()), 64'd1);
    check("t2_accept_id", acc_at(0), 64'd1);
    check("t2_valid_drop", 64'(bus.irq_req_valid), 64'd0);
    csr_write(4'd3, 64'h2);
    csr_read(4'd1, rd);  check("t2_status_clr", rd, 64'h0);

    // two simultaneous edges, served lowest first
    acc_q.delete();
    pulse(4'h5);
    wait_cycles(10);
    check("t3_count", 64'(acc_q.size()), 64'd2);
    check("t3_first", acc_at(0), 64'd0);
    check("t3_second", acc_at(1), 64'd2);
    csr_write(4'd3, 64'h5);
    csr_read(4'd1, rd);  check("t3_status_clr", rd, 64'h0);
    wait_cycles(4);
    check("t3_no_third", 64'(acc_q.size()), 64'd2);

    // masked pending line signalled on unmask
    acc_q.delete();
    csr_write(4'd2, 64'h4);
    pulse(4'h4);
    wait_cycles(8);
    check("t4_masked_none", 64'(acc_q.size()), 64'd0);
    csr_read(4'd1, rd);  check("t4_status", rd, 64'h4);
    csr_write(4'd2, 64'h0);
    wait_cycles(8);
    check("t4_unmask_count", 64'(acc_q.size()), 64'd1);
    check("t4_unmask_id", acc_at(0), 64'd2);
    csr_write(4'd3, 64'h4);

    // clear coinciding with a new edge: set wins and re-signals
    acc_q.delete();
    pulse(4'h2);
    wait_cycles(6);
    check("t5_first", acc_at(0), 64'd1);
    acc_q.delete();
    irq_src = 4'h2;
    bus.avs_address = 4'd3;
    bus.avs_writedata = 64'h2;
    bus.avs_byteenable = 8'hFF;
    bus.avs_write = 1'b1;
    @(negedge clk);
    bus.avs_write = 1'b0;
    irq_src = 4'h0;
    wait_cycles(6);
    check("t5_resignal_count", 64'(acc_q.size()), 64'd1);
    check("t5_resignal_id", acc_at(0), 64'd1);
    csr_read(4'd1, rd);  check("t5_status", rd, 64'h2);
    csr_write(4'd3, 64'h2);

`ifdef ASP_IRQ_STATS_EN
    csr_write(4'd8, 64'h0);
    for (int i = 0; i < 3; i++) begin
      pulse(4'h1);
      wait_cycles(6);
      csr_write(4'd3, 64'h1);
    end
    csr_read(4'd8, rd);  check("stats_three", rd, 64'd3);
    csr_write(4'd8, 64'h0);
    csr_read(4'd8, rd);  check("stats_cleared", rd, 64'd0);
    force dut.gen_stats[0].cnt = 32'hFFFF_FFFF;
    @(negedge clk);
    release dut.gen_stats[0].cnt;
    pulse(4'h1);
    wait_cycles(6);
    csr_write(4'd3, 64'h1);
    csr_read(4'd8, rd);  check("stats_saturate", rd, 64'hFFFF_FFFF);
`else
    csr_read(4'd8, rd);  check("stats_absent", rd, 64'd0);
    csr_write(4'd8, 64'hFF);
    csr_read(4'd8, rd);  check("stats_absent_wr", rd, 64'd0);
`endif

    // reset in the middle of a request: no replay afterwards
    acc_q.delete();
    bus.irq_req_ready = 1'b0;
    pulse(4'h1);
    wait_valid(4);
    check("rst_mid_valid", 64'(bus.irq_req_valid), 64'd1);
    check("rst_mid_id", 64'(bus.irq_req_id), 64'd0);
    reset = 1'b1;
    @(negedge clk);
    check("rst_mid_drop", 64'(bus.irq_req_valid), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    bus.irq_req_ready = 1'b1;
    wait_cycles(8);
    check("rst_no_replay", 64'(acc_q.size()), 64'd0);
    csr_read(4'd2, rd);  check("rst_mid_mask", rd, 64'hF);
    csr_read(4'd1, rd);  check("rst_mid_status", rd, 64'h0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
